alu_req_master: RTL and testbench

// - Initiator side of the ALU request/result interface: accepts operation commands,

---
 rtl/alu_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/alu_req_master.sv | 133 +++++++++++++
 tb/tb_alu_req_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and the response record for the ALU request master.
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CTL_W = 4;
    localparam int DEF_PKT_W = 8;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_PKT_W-1:0] pkt;
        logic [DEF_WIDTH-1:0] res;
        logic                 carry;
        logic                 zero;
    } alu_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout shows the head whenever !empty.
// A pop on a full FIFO frees the slot the same-cycle push writes into.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/alu_req_master.sv
// Initiator for the ALU request/result interface: issues tagged ops, pairs results
// with their tags in order, and buffers them behind a credit-limited response port.
module alu_req_master
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CTL_W = DEF_CTL_W,
    parameter int PKT_W = DEF_PKT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [CTL_W-1:0] cmd_ctl,
    output logic             valid_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic [CTL_W-1:0] ctl,
    output logic [PKT_W-1:0] pkt_num,
    input  logic             valid_out,
    input  logic [WIDTH-1:0] alu,
    input  logic             carry,
    input  logic             zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [PKT_W-1:0] rsp_pkt_num,
    output logic [WIDTH-1:0] rsp_alu,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             err_unexp
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);

    // Handshake rule on both ports: a transfer happens on a rising edge where
    // valid & ready are both high; valid never waits on ready, and the source
    // holds its payload stable while valid is high and ready is low.
    logic [CW-1:0]    credits;
    logic [PKT_W-1:0] next_tag;
    logic             accept;
    logic             rsp_fire;
    logic             capture;

    logic [PKT_W-1:0] tag_head;
    logic             tag_full;
    logic             tag_empty;
    alu_rsp_t         rsp_in;
    alu_rsp_t         rsp_head;
    logic             rsp_full;
    logic             rsp_empty;
    logic             unused_flags;

    assign cmd_ready = (credits != '0);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = !rsp_empty;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign capture   = valid_out && !tag_empty;

    // Credits cover tag FIFO plus response FIFO occupancy, so neither can overflow.
    assign unused_flags = tag_full ^ rsp_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_in  <= 1'b0;
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            ctl       <= '0;
            pkt_num   <= '0;
            next_tag  <= '0;
            credits   <= FULL_CREDITS;
            err_unexp <= 1'b0;
        end else begin
            valid_in <= accept;
            if (accept) begin
                a        <= cmd_a;
                b        <= cmd_b;
                cin      <= cmd_cin;
                ctl      <= cmd_ctl;
                pkt_num  <= next_tag;
                next_tag <= next_tag + PKT_W'(1);
            end
            case ({accept, rsp_fire})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
            if (valid_out && tag_empty) err_unexp <= 1'b1;
        end
    end

    sync_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (next_tag),
        .pop   (capture),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        rsp_in       = '0;
        rsp_in.pkt   = tag_head;
        rsp_in.res   = alu;
        rsp_in.carry = carry;
        rsp_in.zero  = zero;
    end

    sync_fifo #(.W($bits(alu_rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .din   (rsp_in),
        .pop   (rsp_fire),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    assign rsp_pkt_num = rsp_head.pkt;
    assign rsp_alu     = rsp_head.res;
    assign rsp_carry   = rsp_head.carry;
    assign rsp_zero    = rsp_head.zero;

endmodule

// File: tb/tb_alu_req_master.sv
// Bench for alu_req_master: an in-order ALU responder, a queue-based model of the
// master checked every cycle, and directed scenarios with literal expectations.
module tb_alu_req_master;

    localparam int WIDTH = 8;
    localparam int CTL_W = 4;
    localparam int PKT_W = 8;
    localparam int DEPTH = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic [CTL_W-1:0] cmd_ctl;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [CTL_W-1:0] ctl;
    logic [PKT_W-1:0] pkt_num;
    logic             valid_out;
    logic [WIDTH-1:0] alu;
    logic             carry;
    logic             zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [PKT_W-1:0] rsp_pkt_num;
    logic [WIDTH-1:0] rsp_alu;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             err_unexp;

    alu_req_master dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .cmd_ctl     (cmd_ctl),
        .valid_in    (valid_in),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .ctl         (ctl),
        .pkt_num     (pkt_num),
        .valid_out   (valid_out),
        .alu         (alu),
        .carry       (carry),
        .zero        (zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_pkt_num (rsp_pkt_num),
        .rsp_alu     (rsp_alu),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .err_unexp   (err_unexp)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ALU responder (in order, fixed latency) ----------------
    int          cyc = 0;
    int          alu_lat = 2;
    bit          alu_auto = 1'b1;
    int          inj_req = 0;
    int          inj_done = 0;
    int          due_q[$];
    logic [9:0]  res_q[$];

    // returns {carry, zero, result}
    function automatic logic [9:0] alu_fn(logic [7:0] x, logic [7:0] y, logic c, logic [3:0] op);
        logic [8:0] s;
        case (op)
            OP_ADD:  s = {1'b0, x} + {1'b0, y} + {8'b0, c};
            OP_SUB:  s = {1'b0, x} - {1'b0, y} - {8'b0, c};
            default: s = {1'b0, x & y};
        endcase
        return {s[8], (s[7:0] == 8'h00), s[7:0]};
    endfunction

    initial begin
        valid_out = 1'b0;
        alu = '0;
        carry = 1'b0;
        zero = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            valid_out = 1'b0;
            if (inj_req != inj_done) begin
                inj_done = inj_req;
                valid_out = 1'b1;
                {carry, zero, alu} = {1'b1, 1'b0, 8'h55};
            end else if (alu_auto && due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                valid_out = 1'b1;
                {carry, zero, alu} = res_q.pop_front();
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    bit               model_ok = 1'b0;
    int               m_credits;
    logic [7:0]       m_tag;
    logic             m_vin;
    logic [7:0]       m_a, m_b, m_pkt;
    logic             m_cin;
    logic [3:0]       m_ctl;
    logic             m_err;
    logic [7:0]       inflight[$];
    logic [17:0]      exp_q[$];
    logic [7:0]       vin_log[$];
    bit               acc, hs;

    always @(negedge clk) begin
        if (model_ok) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_credits != 0));
            check("valid_in", 32'(valid_in), 32'(m_vin));
            check("issue", {9'b0, a, b, cin, ctl, pkt_num}, {9'b0, m_a, m_b, m_cin, m_ctl, m_pkt});
            check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check("rsp_data", 32'({rsp_pkt_num, rsp_alu, rsp_carry, rsp_zero}), 32'(exp_q[0]));
            check("err_unexp", 32'(err_unexp), 32'(m_err));
            if (valid_in && !reset) begin
                vin_log.push_back(pkt_num);
                due_q.push_back(cyc + alu_lat);
                res_q.push_back(alu_fn(a, b, cin, ctl));
            end
        end
        if (reset) begin
            model_ok = 1'b1;
            m_credits = DEPTH;
            m_tag = 8'h00;
            m_vin = 1'b0;
            {m_a, m_b, m_cin, m_ctl, m_pkt} = '0;
            m_err = 1'b0;
            inflight.delete();
            exp_q.delete();
        end else if (model_ok) begin
            acc = cmd_valid && (m_credits != 0);
            hs = rsp_ready && (exp_q.size() != 0);
            if (hs) void'(exp_q.pop_front());
            if (valid_out) begin
                if (inflight.size() == 0) m_err = 1'b1;
                else exp_q.push_back({inflight.pop_front(), alu, carry, zero});
            end
            m_vin = acc;
            if (acc) begin
                {m_a, m_b, m_cin, m_ctl, m_pkt} = {cmd_a, cmd_b, cmd_cin, cmd_ctl, m_tag};
                inflight.push_back(m_tag);
                m_tag = m_tag + 8'd1;
            end
            m_credits = m_credits - (acc ? 1 : 0) + (hs ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic [3:0] op);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        {cmd_a, cmd_b, cmd_cin, cmd_ctl} = {av, bv, c, op};
        for (int t = 0; t < 200 && !done; t++) begin
            done = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        if (!done) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp();
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (rsp_valid) seen = 1'b1;
            else step();
        end
        if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) step();
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int base;

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        {cmd_a, cmd_b, cmd_cin, cmd_ctl} = '0;
        rsp_ready = 1'b0;
        apply_reset();

        // idle after reset
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid_in", 32'(valid_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(err_unexp), 32'd0);

        // single ADD 5+3
        send_cmd(8'h05, 8'h03, 1'b0, OP_ADD);
        check("single_vin", 32'(valid_in), 32'd1);
        check("single_pkt", 32'(pkt_num), 32'd0);
        wait_rsp();
        check("single_rsp_pkt", 32'(rsp_pkt_num), 32'd0);
        check("single_rsp_alu", 32'(rsp_alu), 32'h08);
        check("single_rsp_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
        drain();

        // four back-to-back with response port stalled
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send_cmd(8'(8'h10 * i), 8'(i + 1), i[0], OP_SUB);
            check("b2b_pkt", 32'(pkt_num), 32'(i));
        end
        check("b2b_full_ready", 32'(cmd_ready), 32'd0);
        repeat (6) step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_rsp_order", 32'({rsp_valid, rsp_pkt_num}), 32'({1'b1, 8'(i)}));
            step();
            if (i == 0) check("b2b_credit_back", 32'(cmd_ready), 32'd1);
        end
        check("b2b_empty", 32'(rsp_valid), 32'd0);
        drain();

        // accept and response handshake in the same cycle, then streaming
        send_cmd(8'hFF, 8'h01, 1'b0, OP_ADD);
        wait_rsp();
        check("wrap_add", 32'({rsp_carry, rsp_zero, rsp_alu}), 32'h300);
        cmd_valid = 1'b1;
        {cmd_a, cmd_b, cmd_cin, cmd_ctl} = {8'h0F, 8'hF0, 1'b0, 4'd2};
        rsp_ready = 1'b1;
        check("simul_pre_ready", 32'(cmd_ready), 32'd1);
        step();
        check("simul_post_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 24; i++) begin
            {cmd_a, cmd_b, cmd_cin, cmd_ctl} = {8'(i * 37), 8'(255 - i * 11), i[1], 4'(i % 3)};
            rsp_ready = (i % 5 != 3);
            step();
        end
        drain();

        // tag wrap across 257 ops
        apply_reset();
        base = vin_log.size();
        rsp_ready = 1'b1;
        for (int i = 0; i < 257; i++) send_cmd(8'(i), 8'(i ^ 8'h5A), 1'b1, OP_ADD);
        drain();
        check("wrap_count", 32'(vin_log.size() - base >= 257), 32'd1);
        if (vin_log.size() - base >= 257) begin
            check("wrap_fe", 32'(vin_log[base + 254]), 32'hFE);
            check("wrap_ff", 32'(vin_log[base + 255]), 32'hFF);
            check("wrap_00", 32'(vin_log[base + 256]), 32'h00);
        end

        // unexpected result with nothing in flight
        apply_reset();
        inj_req++;
        repeat (3) step();
        check("unexp_err", 32'(err_unexp), 32'd1);
        check("unexp_no_rsp", 32'(rsp_valid), 32'd0);

        // reset with two ops in flight; their late results are unexpected
        apply_reset();
        alu_lat = 3;
        send_cmd(8'h21, 8'h12, 1'b0, OP_ADD);
        send_cmd(8'h40, 8'h04, 1'b1, OP_SUB);
        reset = 1'b1;
        step();
        check("mid_rst_vin", 32'(valid_in), 32'd0);
        check("mid_rst_data", 32'({a, b, cin, ctl, pkt_num}), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        check("mid_rst_err", 32'(err_unexp), 32'd0);
        reset = 1'b0;
        repeat (5) step();
        check("late_err", 32'(err_unexp), 32'd1);
        check("late_no_rsp", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
